// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency SRAM between instruction fetch and the MEM stage.
// MEM has priority; a starvation counter forces a fetch through after FETCH_STARVE_MAX MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 32,
    parameter int WAIT_CYCLES      = 3,
    parameter int FETCH_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_If_Req,
    input  logic [ADDR_W-1:0] i_If_Addr,
    output logic              o_If_Ready,
    output logic [DATA_W-1:0] o_If_Data,
    output logic              o_If_Stall,

    input  logic              i_Mem_Read_Enable,
    input  logic              i_Mem_Write_Enable,
    input  logic [ADDR_W-1:0] i_Mem_Addr,
    input  logic [DATA_W-1:0] i_Mem_Wdata,
    output logic              o_Mem_Ready,
    output logic [DATA_W-1:0] o_Mem_Rdata,
    output logic              o_Freeze,

    output logic [ADDR_W-1:0] o_Sram_Addr,
    output logic [DATA_W-1:0] o_Sram_Wdata,
    output logic              o_Sram_We,
    output logic              o_Sram_Oe,
    input  logic [DATA_W-1:0] i_Sram_Rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int STV_W = (FETCH_STARVE_MAX < 1) ? 1 : $clog2(FETCH_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(FETCH_STARVE_MAX);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    state_t           r_state;
    owner_t           r_owner;
    logic             r_write;
    logic [CNT_W-1:0] r_cnt;
    logic [STV_W-1:0] r_starve;

    logic w_mem_req;
    logic w_any_req;
    logic w_if_wins;

    assign w_mem_req = i_Mem_Read_Enable | i_Mem_Write_Enable;
    assign w_any_req = i_If_Req | w_mem_req;
    assign w_if_wins = i_If_Req & (~w_mem_req | (r_starve == STV_MAX));

    // Pipeline handshakes stay combinational so they track the requests even while in reset.
    assign o_Freeze   = w_mem_req & ~o_Mem_Ready;
    assign o_If_Stall = i_If_Req & ~o_If_Ready;

    // NOTE: reset is asynchronous so SRAM strobes drop the instant reset_n falls, aborting any access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_write      <= 1'b0;
            r_cnt        <= '0;
            r_starve     <= '0;
            o_If_Ready   <= 1'b0;
            o_If_Data    <= '0;
            o_Mem_Ready  <= 1'b0;
            o_Mem_Rdata  <= '0;
            o_Sram_Addr  <= '0;
            o_Sram_Wdata <= '0;
            o_Sram_We    <= 1'b0;
            o_Sram_Oe    <= 1'b0;
        end else begin
            o_If_Ready  <= 1'b0;
            o_Mem_Ready <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CNT_INIT;
                        if (w_if_wins) begin
                            r_owner     <= OWN_IF;
                            r_write     <= 1'b0;
                            r_starve    <= '0;
                            o_Sram_Addr <= i_If_Addr;
                            o_Sram_We   <= 1'b0;
                            o_Sram_Oe   <= 1'b1;
                        end else begin
                            // A store wins when both read and write enables are high.
                            r_owner      <= OWN_MEM;
                            r_write      <= i_Mem_Write_Enable;
                            o_Sram_Addr  <= i_Mem_Addr;
                            o_Sram_Wdata <= i_Mem_Wdata;
                            o_Sram_We    <= i_Mem_Write_Enable;
                            o_Sram_Oe    <= ~i_Mem_Write_Enable;
                            if (i_If_Req && (r_starve != STV_MAX)) begin
                                r_starve <= r_starve + STV_ONE;
                            end
                        end
                    end
                end

                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state   <= S_DONE;
                        o_Sram_We <= 1'b0;
                        o_Sram_Oe <= 1'b0;
                        if (r_owner == OWN_IF) begin
                            o_If_Ready <= 1'b1;
                            o_If_Data  <= i_Sram_Rdata;
                        end else begin
                            o_Mem_Ready <= 1'b1;
                            if (!r_write) begin
                                o_Mem_Rdata <= i_Sram_Rdata;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_CYCLES=3) with a word-indexed SRAM model.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        if_stall;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [31:0] sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) sram[pre_idx] <= pre_data;
        else if (sram_we) sram[sram_addr[13:2]] <= sram_wdata;
    end
    assign sram_rdata = sram[sram_addr[13:2]];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .FETCH_STARVE_MAX(4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_If_Req          (if_req),
        .i_If_Addr         (if_addr),
        .o_If_Ready        (if_ready),
        .o_If_Data         (if_data),
        .o_If_Stall        (if_stall),
        .i_Mem_Read_Enable (mem_re),
        .i_Mem_Write_Enable(mem_we),
        .i_Mem_Addr        (mem_addr),
        .i_Mem_Wdata       (mem_wdata),
        .o_Mem_Ready       (mem_ready),
        .o_Mem_Rdata       (mem_rdata),
        .o_Freeze          (freeze),
        .o_Sram_Addr       (sram_addr),
        .o_Sram_Wdata      (sram_wdata),
        .o_Sram_We         (sram_we),
        .o_Sram_Oe         (sram_oe),
        .i_Sram_Rdata      (sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_idx  = addr[13:2];
        pre_data = data;
        pre_we   = 1'b1;
        cyc();
        pre_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] seq;
        int         n_grants;

        reset_n   = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset state and combinational handshakes during reset
        #1;
        check("rst_mem_ready", mem_ready, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_sram_oe", sram_oe, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_if_data", if_data, 0);
        mem_re = 1'b1;
        #1;
        check("rst_freeze_follows", freeze, 1);
        mem_re = 1'b0;
        if_req = 1'b1;
        #1;
        check("rst_stall_follows", if_stall, 1);
        if_req = 1'b0;

        preload(32'h1000_0100, 32'hDEAD_BEEF);
        preload(32'h0000_0020, 32'hCAFE_0020);
        preload(32'h0000_1000, 32'hE3A0_0001);
        preload(32'h0000_1004, 32'hE281_1004);
        preload(32'h0000_0024, 32'hAAAA_0024);
        cyc();
        reset_n = 1'b1;

        // 1: load
        cyc();
        mem_re = 1'b1; mem_addr = 32'h1000_0100;
        #1;
        check("t1_freeze_c0", freeze, 1);
        check("t1_oe_c0", sram_oe, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            check("t1_oe_busy", sram_oe, 1);
            check("t1_we_busy", sram_we, 0);
            check("t1_addr_busy", sram_addr, 32'h1000_0100);
            check("t1_freeze_busy", freeze, 1);
            check("t1_ready_busy", mem_ready, 0);
        end
        cyc(); #1;
        check("t1_ready_c4", mem_ready, 1);
        check("t1_rdata_c4", mem_rdata, 32'hDEAD_BEEF);
        check("t1_freeze_c4", freeze, 0);
        check("t1_oe_c4", sram_oe, 0);
        cyc();
        mem_re = 1'b0;
        #1;
        check("t1_ready_c5", mem_ready, 0);

        // 2: simultaneous fetch and load, MEM first
        cyc();
        if_req = 1'b1; if_addr = 32'h1000;
        mem_re = 1'b1; mem_addr = 32'h20;
        #1;
        check("t2_stall_c0", if_stall, 1);
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            check("t2_mem_addr", sram_addr, 32'h20);
            check("t2_mem_oe", sram_oe, 1);
            check("t2_stall_busy", if_stall, 1);
        end
        cyc(); #1;
        check("t2_mem_ready_c4", mem_ready, 1);
        check("t2_mem_rdata_c4", mem_rdata, 32'hCAFE_0020);
        check("t2_if_ready_c4", if_ready, 0);
        cyc();
        mem_re = 1'b0;
        #1;
        check("t2_oe_c5", sram_oe, 0);
        for (int c = 6; c <= 8; c++) begin
            cyc(); #1;
            check("t2_if_addr", sram_addr, 32'h1000);
            check("t2_if_oe", sram_oe, 1);
        end
        cyc(); #1;
        check("t2_if_ready_c9", if_ready, 1);
        check("t2_if_data_c9", if_data, 32'hE3A0_0001);
        check("t2_stall_c9", if_stall, 0);
        cyc();
        if_req = 1'b0;
        #1;
        check("t2_if_ready_c10", if_ready, 0);

        // 3: starvation guard
        cyc();
        if_req = 1'b1; if_addr = 32'h1004;
        mem_re = 1'b1; mem_addr = 32'h20;
        seq = '0;
        n_grants = 0;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (mem_ready || if_ready) begin
                seq = {seq[4:0], mem_ready};
                n_grants++;
                if (if_ready) check("t3_starve_clear", 32'(dut.r_starve), 0);
            end
            if (n_grants == 6) break;
            cyc(); #1;
        end
        if_req = 1'b0;
        mem_re = 1'b0;
        check("t3_grant_count", n_grants, 6);
        check("t3_grant_order", 32'(seq), 32'(6'b111101));
        cyc();

        // 4: store, then read back
        cyc();
        mem_we = 1'b1; mem_addr = 32'h24; mem_wdata = 32'h1234_5678;
        #1;
        check("t4_we_c0", sram_we, 0);
        cyc(); #1;
        check("t4_we_c1", sram_we, 1);
        check("t4_oe_c1", sram_oe, 0);
        check("t4_addr_c1", sram_addr, 32'h24);
        check("t4_wdata_c1", sram_wdata, 32'h1234_5678);
        cyc();
        mem_addr = 32'h99; mem_wdata = 32'hBAD0_BAD0;
        #1;
        check("t4_addr_stable", sram_addr, 32'h24);
        check("t4_wdata_stable", sram_wdata, 32'h1234_5678);
        check("t4_we_c2", sram_we, 1);
        cyc(); #1;
        check("t4_we_c3", sram_we, 1);
        check("t4_oe_c3", sram_oe, 0);
        cyc(); #1;
        check("t4_ready_c4", mem_ready, 1);
        check("t4_rdata_kept", mem_rdata, 32'hCAFE_0020);
        check("t4_we_c4", sram_we, 0);
        cyc();
        mem_we = 1'b0;
        cyc();
        mem_re = 1'b1; mem_addr = 32'h24;
        repeat (4) cyc();
        #1;
        check("t4_readback_ready", mem_ready, 1);
        check("t4_readback_data", mem_rdata, 32'h1234_5678);
        cyc();
        mem_re = 1'b0;

        // 6: request dropped mid-access
        cyc();
        mem_re = 1'b1; mem_addr = 32'h1000_0100;
        cyc();
        cyc();
        mem_re = 1'b0;
        #1;
        check("t6_freeze_dropped", freeze, 0);
        check("t6_oe_c2", sram_oe, 1);
        cyc();
        cyc(); #1;
        check("t6_ready_c4", mem_ready, 1);
        check("t6_rdata_c4", mem_rdata, 32'hDEAD_BEEF);
        cyc();
        mem_re = 1'b1; mem_addr = 32'h20;
        #1;
        check("t6_oe_c5", sram_oe, 0);
        cyc(); #1;
        check("t6_idle_in_c5", sram_oe, 1);
        repeat (3) cyc();
        #1;
        check("t6_next_ready", mem_ready, 1);
        cyc();
        mem_re = 1'b0;

        // 5: reset mid-access
        cyc();
        mem_re = 1'b1; mem_addr = 32'h20;
        cyc();
        cyc();
        #1;
        check("t5_oe_before_rst", sram_oe, 1);
        reset_n = 1'b0;
        mem_re  = 1'b0;
        #1;
        check("t5_oe_async", sram_oe, 0);
        check("t5_we_async", sram_we, 0);
        for (int c = 0; c < 3; c++) begin
            cyc(); #1;
            check("t5_no_ready", mem_ready, 0);
        end
        cyc();
        reset_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h1004;
        #1;
        check("t5_if_ready_c0", if_ready, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            check("t5_if_ready_busy", if_ready, 0);
        end
        cyc(); #1;
        check("t5_if_ready_c4", if_ready, 1);
        check("t5_if_data_c4", if_data, 32'hE281_1004);
        cyc();
        if_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
